// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage feeding the 2-bit ALU: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Define ALU_ISSUE_STICKY_ERR_EN to make flags_q[0] (E) sticky until a clr_err pulse.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned REG_N  = 4,
  parameter int unsigned OP_W   = 3,
  localparam int unsigned IDX_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [IDX_W-1:0]  instr_rd,
  input  logic [IDX_W-1:0]  instr_rs1,
  input  logic [IDX_W-1:0]  instr_rs2,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              clr_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_error,
  output logic              wb_valid,
  output logic [IDX_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags_q,
  output logic [7:0]        err_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [REG_N];
  logic [OP_W-1:0]   op_q;
  logic [IDX_W-1:0]  rd_q;
  logic [IDX_W-1:0]  rs1_q;
  logic [IDX_W-1:0]  rs2_q;

  assign busy = ~instr_ready;

`ifndef ALU_ISSUE_STICKY_ERR_EN
  logic clr_err_unused;
  assign clr_err_unused = clr_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      flags_q     <= '0;
      err_count   <= '0;
      for (int unsigned i = 0; i < REG_N; i++) rf[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
`ifdef ALU_ISSUE_STICKY_ERR_EN
      if (clr_err) flags_q[0] <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // A preload on the accept edge lands before READ samples the regfile.
          if (cfg_we) rf[cfg_addr] <= cfg_data;
          if (instr_valid) begin
            op_q        <= instr_op;
            rd_q        <= instr_rd;
            rs1_q       <= instr_rs1;
            rs2_q       <= instr_rs2;
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          alu_a   <= rf[rs1_q];
          alu_b   <= rf[rs2_q];
          alu_sel <= op_q;
          state   <= EXEC;
        end
        EXEC: begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd_q;
          flags_q[3:1] <= {alu_zero, alu_carry, alu_overflow};
          if (alu_error) begin
            wb_data <= '0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end else begin
            wb_data   <= alu_out;
            rf[rd_q]  <= alu_out;
          end
`ifdef ALU_ISSUE_STICKY_ERR_EN
          // An errored retire wins over a coincident clear.
          flags_q[0] <= alu_error | (flags_q[0] & ~clr_err);
`else
          flags_q[0] <= alu_error;
`endif
          state <= WB;
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the ALU is a per-vector stub whose response is set by each vector.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_op = '0;
  logic [1:0] instr_rd = '0;
  logic [1:0] instr_rs1 = '0;
  logic [1:0] instr_rs2 = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [1:0] cfg_data = '0;
  logic       clr_err = 1'b0;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [2:0] alu_sel;
  logic [1:0] alu_out = '0;
  logic       alu_zero = 1'b0;
  logic       alu_carry = 1'b0;
  logic       alu_overflow = 1'b0;
  logic       alu_error = 1'b0;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [1:0] wb_data;
  logic [3:0] flags_q;
  logic [7:0] err_count;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.DATA_W(2), .REG_N(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .clr_err(clr_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_error(alu_error),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flags_q(flags_q), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [1:0] addr, input logic [1:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // resp = {Z,C,O,E} reported by the stub ALU for this instruction.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [1:0] ea, input logic [1:0] eb,
                       input logic [1:0] ro, input logic [3:0] resp, input logic [1:0] ewd,
                       input logic [3:0] eflags, input int eerr,
                       input logic acc_cfg, input logic [1:0] caddr, input logic [1:0] cdata);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    alu_out = ro; {alu_zero, alu_carry, alu_overflow, alu_error} = resp;
    cfg_we = acc_cfg; cfg_addr = caddr; cfg_data = cdata;
    check("ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0; cfg_we = 1'b0;
    check("busy_read", busy, 1);
    @(posedge clk); #1;
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_sel", alu_sel, op);
    check("wb_valid_exec", wb_valid, 0);
    @(posedge clk); #1;
    check("wb_valid_c3", wb_valid, 1);
    check("wb_rd", wb_rd, rd);
    check("wb_data", wb_data, ewd);
    check("flags_q", flags_q, eflags);
    check("err_count", err_count, eerr);
    @(posedge clk); #1;
    check("wb_valid_pulse", wb_valid, 0);
    check("ready_back", instr_ready, 1);
  endtask

  int ready_cnt;
  int wb_cnt;
  logic e_after;

  initial begin
`ifdef ALU_ISSUE_STICKY_ERR_EN
    e_after = 1'b1;
`else
    e_after = 1'b0;
`endif
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_flags", flags_q, 0);
    check("rst_err", err_count, 0);
    check("rst_sel", alu_sel, 0);
    @(negedge clk); rst = 1'b0;

    // 1: 01 + 01
    preload(2'd0, 2'b01);
    preload(2'd1, 2'b01);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 2'b01, 2'b01, 2'b10, 4'b0000, 2'b10, 4'b0000, 0, 1'b0, 2'd0, 2'd0);
    // 2: 11 + 01 wraps to 00 with Z and C
    preload(2'd3, 2'b11);
    issue(3'b000, 2'd0, 2'd3, 2'd1, 2'b11, 2'b01, 2'b00, 4'b1100, 2'b00, 4'b1100, 0, 1'b0, 2'd0, 2'd0);
    // r2=10 and r0=00 observed as operands
    issue(3'b011, 2'd1, 2'd2, 2'd0, 2'b10, 2'b00, 2'b10, 4'b0000, 2'b10, 4'b0000, 0, 1'b0, 2'd0, 2'd0);

    // 3: invalid op writes nothing, then a clean ADD
    issue(3'b100, 2'd2, 2'd1, 2'd1, 2'b10, 2'b10, 2'b01, 4'b0001, 2'b00, 4'b0001, 1, 1'b0, 2'd0, 2'd0);
    issue(3'b000, 2'd3, 2'd2, 2'd2, 2'b10, 2'b10, 2'b00, 4'b1110, 2'b00, {3'b111, e_after}, 1, 1'b0, 2'd0, 2'd0);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("flags_after_clr", flags_q, 4'b1110);

    // 4: continuous valid; cfg_we during EXEC is dropped
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b010; instr_rd = 2'd0; instr_rs1 = 2'd3; instr_rs2 = 2'd3;
    alu_out = 2'b00; {alu_zero, alu_carry, alu_overflow, alu_error} = 4'b1000;
    ready_cnt = 0; wb_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      ready_cnt += int'(instr_ready);
      wb_cnt += int'(wb_valid);
      if (i == 2) begin cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 2'b01; end
      if (i == 3) cfg_we = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("ready_1_in_4", ready_cnt, 3);
    check("wb_1_in_4", wb_cnt, 3);
    check("flags_and", flags_q, 4'b1000);
    issue(3'b011, 2'd1, 2'd2, 2'd0, 2'b10, 2'b00, 2'b10, 4'b0000, 2'b10, 4'b0000, 1, 1'b0, 2'd0, 2'd0);
    // cfg on the accept edge is visible to READ
    issue(3'b001, 2'd3, 2'd0, 2'd1, 2'b11, 2'b10, 2'b01, 4'b0000, 2'b01, 4'b0000, 1, 1'b1, 2'd0, 2'b11);

    // 5: reset in EXEC aborts the instruction
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b000; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    alu_out = 2'b10; {alu_zero, alu_carry, alu_overflow, alu_error} = 4'b0001;
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check("rst_exec_ready", instr_ready, 1);
    check("rst_exec_wb", wb_valid, 0);
    check("rst_exec_flags", flags_q, 0);
    check("rst_exec_err", err_count, 0);
    @(negedge clk); rst = 1'b0;
    wb_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb_cnt += int'(wb_valid);
    end
    check("no_wb_after_rst", wb_cnt, 0);
    issue(3'b011, 2'd0, 2'd0, 2'd1, 2'b00, 2'b00, 2'b00, 4'b1000, 2'b00, 4'b1000, 0, 1'b0, 2'd0, 2'd0);
    issue(3'b011, 2'd0, 2'd2, 2'd3, 2'b00, 2'b00, 2'b00, 4'b1000, 2'b00, 4'b1000, 0, 1'b0, 2'd0, 2'd0);

    // 6: err_count saturation
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b111; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
    alu_out = 2'b00; {alu_zero, alu_carry, alu_overflow, alu_error} = 4'b0001;
    for (int i = 0; i < 255 * 4; i++) @(negedge clk);
    check("err_255", err_count, 255);
    for (int i = 0; i < 8; i++) @(negedge clk);
    instr_valid = 1'b0;
    check("err_sat", err_count, 255);
    check("err_flag", flags_q[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
